pool1_layer_ctrl: RTL and testbench

//  Sequencer for the pooling-1 layer (2x2 max, stride 2).
//  - Reads the 24x24 conv-1 output memory over two read ports.
//  - Drives first/last framing to the pooling datapath.
//  - Writes the 12x12 pooled result into P1 memory over two write ports:

---
 rtl/pool1_layer_ctrl_pkg.sv | 38 +++
 rtl/pool1_layer_ctrl_if.sv | 39 +++
 rtl/pool1_layer_ctrl_addr_gen.sv | 16 +
 rtl/pool1_layer_ctrl.sv | 137 +++++++++++++
 tb/tb_pool1_layer_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool1_layer_ctrl_pkg.sv
// Shared constants, state encoding and pixel-address helper for the pooling-1 layer sequencer.
package cnn_pkg;

    localparam int unsigned IMG_IN   = 24;
    localparam int unsigned IMG_OUT  = IMG_IN / 2;
    localparam int unsigned MEM_LAT  = 1;
    localparam int unsigned POOL_LAT = 1;
    localparam int unsigned N_WIN    = IMG_OUT * IMG_OUT;
    localparam int unsigned P1_HALF  = N_WIN / 2;

    localparam int unsigned C1_AW = 10;
    localparam int unsigned P1_AW = 8;
    localparam int unsigned K_W   = 7;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } p1_state_t;

    typedef struct packed {
        logic           first;
        logic           last;
        logic [K_W-1:0] k;
    } frame_t;

    // ph[1] selects the lower row of the 2x2 window, ph[0] the right column.
    function automatic logic [C1_AW-1:0] c1_pixel_addr(input int unsigned win, input logic [1:0] ph);
        int unsigned r;
        int unsigned c;
        r = win / IMG_OUT;
        c = win % IMG_OUT;
        return C1_AW'((2 * r + 32'(ph[1])) * IMG_IN + 2 * c + 32'(ph[0]));
    endfunction

endpackage

// File: rtl/pool1_layer_ctrl_if.sv
// Control/address bundle between the pooling-1 sequencer and its memories/datapath.
// cycle_cnt exists only when POOL1_CYCLE_COUNT_EN is defined.
interface pool1_layer_ctrl_if;
    import cnn_pkg::*;

    logic             start;
    logic             hold;
    logic [C1_AW-1:0] c1_addr0;
    logic [C1_AW-1:0] c1_addr1;
    logic             pool_first;
    logic             pool_last;
    logic [P1_AW-1:0] p1_addr0;
    logic [P1_AW-1:0] p1_addr1;
    logic             p1_we;
    logic             busy;
    logic             done;
`ifdef POOL1_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_cnt;
`endif

    modport slave (
        input  start, hold,
        output c1_addr0, c1_addr1, pool_first, pool_last,
               p1_addr0, p1_addr1, p1_we, busy, done
`ifdef POOL1_CYCLE_COUNT_EN
       ,output cycle_cnt
`endif
    );

    modport master (
        output start, hold,
        input  c1_addr0, c1_addr1, pool_first, pool_last,
               p1_addr0, p1_addr1, p1_we, busy, done
`ifdef POOL1_CYCLE_COUNT_EN
       ,input  cycle_cnt
`endif
    );

endinterface

// File: rtl/pool1_layer_ctrl_addr_gen.sv
// Combinational (window, phase) -> conv-1 read addresses for both halves of the layer.
module pool1_addr_gen
    import cnn_pkg::*;
(
    input  logic [K_W-1:0]   k_i,
    input  logic [1:0]       ph_i,
    output logic [C1_AW-1:0] c1_addr0_o,
    output logic [C1_AW-1:0] c1_addr1_o
);

    always_comb begin
        c1_addr0_o = c1_pixel_addr(32'(k_i), ph_i);
        c1_addr1_o = c1_pixel_addr(32'(k_i) + P1_HALF, ph_i);
    end

endmodule

// File: rtl/pool1_layer_ctrl.sv
// Pooling-1 layer sequencer: 2x2/stride-2 window reads, pooling framing, P1 writes.
// Optional POOL1_CYCLE_COUNT_EN adds a busy-cycle counter on the interface.
module pool1_layer_ctrl
    import cnn_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    pool1_layer_ctrl_if.slave  bus
);

    localparam logic [K_W-1:0] K_LAST = K_W'(P1_HALF - 1);

    p1_state_t        state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [1:0]       ph_q, ph_d;
    frame_t           fr_q [MEM_LAT];
    logic             we_q [POOL_LAT];
    logic [K_W-1:0]   wk_q [POOL_LAT];
    logic             upstream_busy;
    logic [C1_AW-1:0] a0, a1;

    pool1_addr_gen u_addr_gen (
        .k_i        (k_q),
        .ph_i       (ph_q),
        .c1_addr0_o (a0),
        .c1_addr1_o (a1)
    );

    // Anything still in flight ahead of the write stage blocks DRAIN -> DONE.
    always_comb begin
        upstream_busy = 1'b0;
        for (int unsigned i = 0; i < MEM_LAT; i++)
            upstream_busy = upstream_busy | fr_q[i].first | fr_q[i].last;
        for (int unsigned i = 0; i + 1 < POOL_LAT; i++)
            upstream_busy = upstream_busy | we_q[i];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ph_d    = ph_q;
        if (!bus.hold) begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = READ;
                        k_d     = '0;
                        ph_d    = '0;
                    end
                end
                READ: begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (k_q == K_LAST) begin
                            state_d = DRAIN;
                            k_d     = '0;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!upstream_busy && we_q[POOL_LAT-1])
                        state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
        end
    end

    // Write address only loads on a window's last pixel so it stays stable between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MEM_LAT; i++)
                fr_q[i] <= '0;
            for (int unsigned i = 0; i < POOL_LAT; i++) begin
                we_q[i] <= 1'b0;
                wk_q[i] <= '0;
            end
        end else if (!bus.hold) begin
            fr_q[0] <= '{first: (state_q == READ) && (ph_q == 2'd0),
                         last:  (state_q == READ) && (ph_q == 2'd3),
                         k:     k_q};
            for (int unsigned i = 1; i < MEM_LAT; i++)
                fr_q[i] <= fr_q[i-1];
            we_q[0] <= fr_q[MEM_LAT-1].last;
            if (fr_q[MEM_LAT-1].last)
                wk_q[0] <= fr_q[MEM_LAT-1].k;
            for (int unsigned i = 1; i < POOL_LAT; i++) begin
                we_q[i] <= we_q[i-1];
                if (we_q[i-1])
                    wk_q[i] <= wk_q[i-1];
            end
        end
    end

    assign bus.c1_addr0   = (state_q == READ) ? a0 : '0;
    assign bus.c1_addr1   = (state_q == READ) ? a1 : '0;
    assign bus.pool_first = fr_q[MEM_LAT-1].first & ~bus.hold;
    assign bus.pool_last  = fr_q[MEM_LAT-1].last & ~bus.hold;
    assign bus.p1_we      = we_q[POOL_LAT-1] & ~bus.hold;
    assign bus.p1_addr0   = P1_AW'(wk_q[POOL_LAT-1]);
    assign bus.p1_addr1   = P1_AW'(wk_q[POOL_LAT-1]) + P1_AW'(P1_HALF);
    assign bus.busy       = (state_q == READ) || (state_q == DRAIN);
    assign bus.done       = (state_q == DONE);

`ifdef POOL1_CYCLE_COUNT_EN
    logic             accept;
    logic [CNT_W-1:0] cnt_q;

    assign accept = !bus.hold && bus.start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= '0;
        else if (!bus.hold && ((state_q == READ) || (state_q == DRAIN)))
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pool1_layer_ctrl.sv
// Scoreboard bench for pool1_layer_ctrl: window-scan reference model, randomized hold/start.
module tb_pool1_layer_ctrl;
    import cnn_pkg::*;

    typedef struct {
        int a0;
        int a1;
        int ph;
    } rd_t;

    typedef struct {
        int a0;
        int a1;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pool1_layer_ctrl_if bus ();

    pool1_layer_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rd_t rq[$];
    wr_t wq[$];

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    int exp_done_rel = 291;
    int exp_first_we_rel = -1;
    int hold_cnt = 0;
    bit active = 1'b0;
    bit done_seen = 1'b0;
    bit first_we_seen = 1'b0;
    bit pend_first, pend_last, pend_we;
    bit prev_hold;
    int prev_a0, prev_a1;

    always @(posedge clk) edge_cnt++;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scan the 12x12 output grid in raster order; top half on port0, bottom half on port1.
    function automatic void push_layer();
        rq.delete();
        wq.delete();
        for (int wr = 0; wr < 6; wr++) begin
            for (int wc = 0; wc < 12; wc++) begin
                for (int y = 0; y < 2; y++) begin
                    for (int x = 0; x < 2; x++) begin
                        rd_t r;
                        r.a0 = (2 * wr + y) * 24 + 2 * wc + x;
                        r.a1 = (2 * (wr + 6) + y) * 24 + 2 * wc + x;
                        r.ph = y * 2 + x;
                        rq.push_back(r);
                    end
                end
                begin
                    wr_t w;
                    w.a0 = wr * 12 + wc;
                    w.a1 = wr * 12 + wc + 72;
                    wq.push_back(w);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        int rel;
        rel = edge_cnt - start_edge;
        if (reset && active && rel >= 1) begin
            chk("busy", int'(bus.busy), int'(rel < exp_done_rel));
            chk("done", int'(bus.done), int'(rel >= exp_done_rel));
            if (bus.hold) begin
                chk("held_pool_first", int'(bus.pool_first), 0);
                chk("held_pool_last", int'(bus.pool_last), 0);
                chk("held_p1_we", int'(bus.p1_we), 0);
                if (prev_hold) begin
                    chk("frozen_c1_addr0", int'(bus.c1_addr0), prev_a0);
                    chk("frozen_c1_addr1", int'(bus.c1_addr1), prev_a1);
                end
            end else begin
                chk("pool_first", int'(bus.pool_first), int'(pend_first));
                chk("pool_last", int'(bus.pool_last), int'(pend_last));
                chk("p1_we", int'(bus.p1_we), int'(pend_we));
                pend_we = pend_last;
                if (bus.p1_we) begin
                    if (wq.size() == 0) begin
                        chk("extra_p1_we", 1, 0);
                    end else begin
                        wr_t w;
                        w = wq.pop_front();
                        chk("p1_addr0", int'(bus.p1_addr0), w.a0);
                        chk("p1_addr1", int'(bus.p1_addr1), w.a1);
                    end
                    if (!first_we_seen) begin
                        first_we_seen = 1'b1;
                        if (exp_first_we_rel > 0)
                            chk("first_we_cycle", rel, exp_first_we_rel);
                    end
                end
                if (rq.size() > 0 && bus.busy) begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("c1_addr0", int'(bus.c1_addr0), r.a0);
                    chk("c1_addr1", int'(bus.c1_addr1), r.a1);
                    pend_first = (r.ph == 0);
                    pend_last  = (r.ph == 3);
                end else begin
                    pend_first = 1'b0;
                    pend_last  = 1'b0;
                end
            end
            if (bus.done && !done_seen) begin
                done_seen = 1'b1;
                chk("done_cycle", rel, exp_done_rel);
                chk("reads_left", rq.size(), 0);
                chk("writes_left", wq.size(), 0);
            end
        end
        prev_hold = bus.hold;
        prev_a0   = int'(bus.c1_addr0);
        prev_a1   = int'(bus.c1_addr1);
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_p1_we"}, int'(bus.p1_we), 0);
        chk({tag, "_pool_first"}, int'(bus.pool_first), 0);
        chk({tag, "_pool_last"}, int'(bus.pool_last), 0);
        chk({tag, "_c1_addr0"}, int'(bus.c1_addr0), 0);
        chk({tag, "_c1_addr1"}, int'(bus.c1_addr1), 0);
        chk({tag, "_p1_addr0"}, int'(bus.p1_addr0), 0);
        chk({tag, "_p1_addr1"}, int'(bus.p1_addr1), 72);
    endtask

    task automatic start_layer(input int first_we_rel);
        @(posedge clk);
        #2;
        push_layer();
        pend_first       = 1'b0;
        pend_last        = 1'b0;
        pend_we          = 1'b0;
        done_seen        = 1'b0;
        first_we_seen    = 1'b0;
        hold_cnt         = 0;
        exp_done_rel     = 291;
        exp_first_we_rel = first_we_rel;
        start_edge       = edge_cnt;
        active           = 1'b1;
        bus.start        = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    // mode 0: stray start mid-READ; 1: 5-cycle hold at k=10 ph=2; 2: random hold and start.
    task automatic run_body(input int mode);
        for (int guard = 0; guard < 450 && !done_seen; guard++) begin
            int rel;
            bit h, s;
            @(posedge clk);
            #2;
            rel = edge_cnt - start_edge;
            h = 1'b0;
            s = 1'b0;
            case (mode)
                0: s = (rel == 100);
                1: h = (rel >= 43 && rel <= 47);
                default: begin
                    if (rel >= 2 && rel <= 280)
                        h = ($urandom % 8 == 0);
                    if (rel >= 5 && rel <= 270)
                        s = ($urandom % 16 == 0);
                end
            endcase
            bus.hold  = h;
            bus.start = s;
            if (h) begin
                hold_cnt++;
                exp_done_rel = 291 + hold_cnt;
            end
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        if (!done_seen)
            chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #2;
`ifdef POOL1_CYCLE_COUNT_EN
        chk("cycle_cnt", int'(bus.cycle_cnt), 290);
`endif
        active = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_idle("in_reset");
        reset = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #2;
            chk_idle("idle");
        end

        start_layer(6);
        run_body(0);

        start_layer(6);
        run_body(1);

        start_layer(-1);
        run_body(2);
        start_layer(-1);
        run_body(2);

        start_layer(6);
        for (int guard = 0; guard < 400; guard++) begin
            @(posedge clk);
            #2;
            if (edge_cnt - start_edge == 162)
                break;
        end
        chk("we_before_reset", int'(bus.p1_we), 1);
        active = 1'b0;
        reset  = 1'b0;
        #1;
        chk_idle("mid_reset");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk_idle("after_reset");

        start_layer(6);
        run_body(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
